io_ctrl_sequencer: RTL and testbench

// - Control sequencer upstream of the Datapath. Replaces hand-driven bench strobes with an FSM.
// - Fetch is T0-T2. T3 executes the class-2 register/IO ops: in, out, mfhi, mflo, nop, halt.
// - Outputs connect 1:1 to the Datapath control inputs; the only feedback is IR[31:27].

---
 rtl/cpu_ctrl_pkg.sv | 34 +++
 rtl/io_op_decode.sv | 24 ++
 rtl/io_ctrl_sequencer.sv | 151 +++++++++++++++
 tb/tb_io_ctrl_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control constants: opcode encodings, ALU increment code, sequencer state encodings.
package cpu_ctrl_pkg;

    localparam int          OPC_W   = 5;
    localparam logic [4:0]  ALU_INC = 5'd19;

    localparam logic [OPC_W-1:0] OP_IN   = 5'b10110;
    localparam logic [OPC_W-1:0] OP_OUT  = 5'b10111;
    localparam logic [OPC_W-1:0] OP_MFHI = 5'b11000;
    localparam logic [OPC_W-1:0] OP_MFLO = 5'b11001;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {
        ST_RST,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_PAUSE,
        ST_HALT
    } ctrl_state_t;

    typedef struct packed {
        logic is_in;
        logic is_out;
        logic is_mfhi;
        logic is_mflo;
        logic is_nop;
        logic is_halt;
        logic illegal;
    } io_dec_t;

endpackage

// File: rtl/io_op_decode.sv
// Class-2 register/IO opcode decoder.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the opcode.
module io_op_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opc,
    output io_dec_t          dec
);

    always_comb begin
        dec = '0;
        case (opc)
            OP_IN:   dec.is_in   = 1'b1;
            OP_OUT:  dec.is_out  = 1'b1;
            OP_MFHI: dec.is_mfhi = 1'b1;
            OP_MFLO: dec.is_mflo = 1'b1;
            OP_NOP:  dec.is_nop  = 1'b1;
            OP_HALT: dec.is_halt = 1'b1;
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/io_ctrl_sequencer.sv
// Fetch/execute control sequencer driving the datapath strobes for class-2 register/IO ops.
// Latency: fixed 4 cycles per instruction (T0-T3); outputs are Moore-decoded from state and latched opcode.
// Backpressure: stop pauses at the instruction boundary after T3; halt parks until clr.
module io_ctrl_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int         OPC_W_P   = OPC_W,
    parameter logic [4:0] ALU_INC_P = ALU_INC
)
(
    input  logic        clk,
    input  logic        clr,
    input  logic        stop,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        Rout,
    output logic        InPort_read,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Zin,
    output logic        Rin,
    output logic        OutPort_write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        BAout,
    output logic        pc_increment,
    output logic        read,
    output logic        memoryRead,
    output logic [4:0]  alu_control,
    output logic        run,
    output logic        instr_done,
    output logic        illegal_op
);

    ctrl_state_t        state;
    ctrl_state_t        state_nxt;
    logic [OPC_W_P-1:0] opc_q;
    io_dec_t            dec;
    logic               unused_ir_bits;

    assign unused_ir_bits = ^ir[31-OPC_W_P:0];

    // The opcode is captured as the T2->T3 edge, i.e. the same edge the datapath loads IR.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_RST;
            opc_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_T2) begin
                opc_q <= ir[31 -: OPC_W_P];
            end
        end
    end

    io_op_decode u_dec (
        .opc (opc_q),
        .dec (dec)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST:   state_nxt = ST_T0;
            ST_T0:    state_nxt = ST_T1;
            ST_T1:    state_nxt = ST_T2;
            ST_T2:    state_nxt = ST_T3;
            ST_T3: begin
                if (dec.is_halt) begin
                    state_nxt = ST_HALT;
                end else if (stop) begin
                    state_nxt = ST_PAUSE;
                end else begin
                    state_nxt = ST_T0;
                end
            end
            ST_PAUSE: state_nxt = stop ? ST_PAUSE : ST_T0;
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_RST;
        endcase
    end

    always_comb begin
        PCout         = 1'b0;
        Zlowout       = 1'b0;
        MDRout        = 1'b0;
        HIout         = 1'b0;
        LOout         = 1'b0;
        Rout          = 1'b0;
        InPort_read   = 1'b0;
        MARin         = 1'b0;
        PCin          = 1'b0;
        MDRin         = 1'b0;
        IRin          = 1'b0;
        Zin           = 1'b0;
        Rin           = 1'b0;
        OutPort_write = 1'b0;
        Gra           = 1'b0;
        Grb           = 1'b0;
        Grc           = 1'b0;
        BAout         = 1'b0;
        pc_increment  = 1'b0;
        read          = 1'b0;
        memoryRead    = 1'b0;
        alu_control   = 5'd0;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        run           = (state != ST_PAUSE) && (state != ST_HALT);
        case (state)
            ST_T0: begin
                PCout        = 1'b1;
                MARin        = 1'b1;
                Zin          = 1'b1;
                pc_increment = 1'b1;
                alu_control  = ALU_INC_P;
            end
            ST_T1: begin
                Zlowout    = 1'b1;
                PCin       = 1'b1;
                read       = 1'b1;
                memoryRead = 1'b1;
                MDRin      = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                instr_done    = 1'b1;
                illegal_op    = dec.illegal;
                Gra           = dec.is_in | dec.is_out | dec.is_mfhi | dec.is_mflo;
                Rin           = dec.is_in | dec.is_mfhi | dec.is_mflo;
                InPort_read   = dec.is_in;
                Rout          = dec.is_out;
                OutPort_write = dec.is_out;
                HIout         = dec.is_mfhi;
                LOout         = dec.is_mflo;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_io_ctrl_sequencer.sv
// Scoreboarded bench: driver advances a spec-level phase model and queues expected outputs per cycle;
// a negedge monitor pops and compares whatever the DUT presents.
module tb_io_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        stop = 1'b0;
    logic [31:0] ir = '0;

    logic PCout, Zlowout, MDRout, HIout, LOout, Rout, InPort_read;
    logic MARin, PCin, MDRin, IRin, Zin, Rin, OutPort_write;
    logic Gra, Grb, Grc, BAout, pc_increment, read, memoryRead;
    logic [4:0] alu_control;
    logic run, instr_done, illegal_op;

    always #5 clk = ~clk;

    io_ctrl_sequencer dut (
        .clk(clk), .clr(clr), .stop(stop), .ir(ir),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
        .Rout(Rout), .InPort_read(InPort_read), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Zin(Zin), .Rin(Rin), .OutPort_write(OutPort_write), .Gra(Gra),
        .Grb(Grb), .Grc(Grc), .BAout(BAout), .pc_increment(pc_increment), .read(read),
        .memoryRead(memoryRead), .alu_control(alu_control), .run(run),
        .instr_done(instr_done), .illegal_op(illegal_op)
    );

    localparam logic [4:0] T_IN   = 5'b10110;
    localparam logic [4:0] T_OUT  = 5'b10111;
    localparam logic [4:0] T_MFHI = 5'b11000;
    localparam logic [4:0] T_MFLO = 5'b11001;
    localparam logic [4:0] T_NOP  = 5'b11010;
    localparam logic [4:0] T_HALT = 5'b11011;

    typedef struct packed {
        logic PCout, Zlowout, MDRout, HIout, LOout, Rout, InPort_read;
        logic MARin, PCin, MDRin, IRin, Zin, Rin, OutPort_write;
        logic Gra, Grb, Grc, BAout, pc_increment, read, memoryRead;
        logic [4:0] alu_control;
        logic run, instr_done, illegal_op;
    } outs_t;

    typedef enum int {P_RST, P_T0, P_T1, P_T2, P_T3, P_PAUSE, P_HALT} phase_t;

    phase_t     phase = P_RST;
    logic [4:0] m_opc = '0;
    outs_t      exp_q[$];
    phase_t     ph_q[$];
    int         exp_done = 0;
    int         exp_fetch = 0;
    int         cyc = 0;
    bit         fin_req = 1'b0;

    int tests = 0;
    int fails = 0;
    int got_done = 0;
    int got_fetch = 0;

    // Expected outputs straight from the per-state strobe table.
    function automatic outs_t model_outs(phase_t p, logic [4:0] op);
        outs_t v = '0;
        case (p)
            P_RST: v.run = 1'b1;
            P_T0: begin
                v.run = 1'b1; v.PCout = 1'b1; v.MARin = 1'b1; v.Zin = 1'b1;
                v.pc_increment = 1'b1; v.alu_control = 5'd19;
            end
            P_T1: begin
                v.run = 1'b1; v.Zlowout = 1'b1; v.PCin = 1'b1; v.read = 1'b1;
                v.memoryRead = 1'b1; v.MDRin = 1'b1;
            end
            P_T2: begin
                v.run = 1'b1; v.MDRout = 1'b1; v.IRin = 1'b1;
            end
            P_T3: begin
                v.run = 1'b1; v.instr_done = 1'b1;
                if (op == T_IN) begin
                    v.Gra = 1'b1; v.Rin = 1'b1; v.InPort_read = 1'b1;
                end else if (op == T_OUT) begin
                    v.Gra = 1'b1; v.Rout = 1'b1; v.OutPort_write = 1'b1;
                end else if (op == T_MFHI) begin
                    v.Gra = 1'b1; v.Rin = 1'b1; v.HIout = 1'b1;
                end else if (op == T_MFLO) begin
                    v.Gra = 1'b1; v.Rin = 1'b1; v.LOout = 1'b1;
                end else if (op != T_NOP && op != T_HALT) begin
                    v.illegal_op = 1'b1;
                end
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    // One clock: apply inputs, advance the model at the edge, queue the expected outputs.
    task automatic step(input logic c, input logic s, input logic [4:0] op);
        logic [31:0] ir_v;
        ir_v = (phase == P_T2) ? {op, 27'($urandom)} : $urandom;
        clr  = c;
        stop = s;
        ir   = ir_v;
        @(posedge clk);
        if (c) begin
            phase = P_RST;
        end else begin
            case (phase)
                P_RST:   phase = P_T0;
                P_T0:    phase = P_T1;
                P_T1:    phase = P_T2;
                P_T2: begin
                    m_opc = ir_v[31:27];
                    phase = P_T3;
                end
                P_T3:    phase = (m_opc == T_HALT) ? P_HALT : (s ? P_PAUSE : P_T0);
                P_PAUSE: phase = s ? P_PAUSE : P_T0;
                default: phase = P_HALT;
            endcase
        end
        if (phase == P_T3) exp_done++;
        if (phase == P_T0) exp_fetch++;
        #1;
        exp_q.push_back(model_outs(phase, m_opc));
        ph_q.push_back(phase);
        cyc++;
    endtask

    // Runs until the instruction reaches T3; optional stop from T1 held for pause_len cycles after T3.
    task automatic run_op(input logic [4:0] op, input bit stop_t1, input int pause_len, input bit rnd_clr);
        bit s = 1'b0;
        int guard = 0;
        logic c;
        do begin
            if (phase == P_T1 && stop_t1) s = 1'b1;
            c = rnd_clr && ($urandom_range(0, 63) == 0);
            step(c, s, op);
            guard++;
        end while (phase != P_T3 && guard < 16);
        for (int k = 0; k < pause_len; k++) step(1'b0, 1'b1, op);
    endtask

    function automatic logic [4:0] pick_op();
        case ($urandom_range(0, 11))
            0, 1:    return T_IN;
            2, 3:    return T_OUT;
            4:       return T_MFHI;
            5:       return T_MFLO;
            6, 7:    return T_NOP;
            8:       return T_HALT;
            default: return 5'($urandom);
        endcase
    endfunction

    initial begin
        logic [4:0] op;
        step(1'b1, 1'b0, 5'd0);
        step(1'b1, 1'b0, 5'd0);
        run_op(T_OUT,  1'b0, 0, 1'b0);
        run_op(T_IN,   1'b0, 0, 1'b0);
        run_op(T_MFHI, 1'b0, 0, 1'b0);
        run_op(T_MFLO, 1'b0, 0, 1'b0);
        run_op(T_NOP,  1'b1, 3, 1'b0);
        run_op(T_HALT, 1'b1, 2, 1'b0);
        repeat (4) step(1'b0, 1'($urandom), 5'd0);
        step(1'b1, 1'b0, 5'd0);
        run_op(5'h1F, 1'b0, 0, 1'b0);
        run_op(T_NOP, 1'b0, 0, 1'b0);
        for (int n = 0; n < 300; n++) begin
            op = pick_op();
            run_op(op, 1'($urandom_range(0, 3) == 0), $urandom_range(0, 3), 1'b1);
            if (phase == P_T3 && op == T_HALT) begin
                repeat (3) step(1'b0, 1'($urandom), 5'd0);
                step(1'b1, 1'b0, 5'd0);
            end
        end
        step(1'b0, 1'b0, 5'd0);
        fin_req = 1'b1;
    end

    always @(negedge clk) begin
        outs_t  a;
        outs_t  e;
        phase_t p;
        if (exp_q.size() > 0) begin
            a = {PCout, Zlowout, MDRout, HIout, LOout, Rout, InPort_read,
                 MARin, PCin, MDRin, IRin, Zin, Rin, OutPort_write,
                 Gra, Grb, Grc, BAout, pc_increment, read, memoryRead,
                 alu_control, run, instr_done, illegal_op};
            e = exp_q.pop_front();
            p = ph_q.pop_front();
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL outs cycle %0d phase %s: got %08h want %08h", tests, p.name(), a, e);
            end
            if (a.instr_done === 1'b1) got_done++;
            if (a.PCout === 1'b1) got_fetch++;
        end
        if (fin_req && exp_q.size() == 0) begin
            tests++;
            if (got_done != exp_done) begin
                fails++;
                $display("FAIL instr_done_count: got %0d want %0d", got_done, exp_done);
            end
            tests++;
            if (got_fetch != exp_fetch) begin
                fails++;
                $display("FAIL fetch_count: got %0d want %0d", got_fetch, exp_fetch);
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish by %0t want finish", $time);
        $fatal(1, "bench timeout");
    end

endmodule
